// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter and its FIFO.
package wb_arbiter_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO; head is the oldest entry, valid when count_o != 0.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;

  // Depth is a power of two, so pointers wrap naturally at PtrW bits.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU and long-latency result paths onto the single
// register-file write port, buffering losing long-latency results in a FIFO.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [REG_W-1:0]         alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ll_valid,
  output logic                     ll_ready,
  input  logic [REG_W-1:0]         ll_rd,
  input  logic [XLEN-1:0]          ll_data,
  output logic                     wb_en,
  output logic [REG_W-1:0]         wb_reg,
  output logic [XLEN-1:0]          wb_data,
  output logic                     alu_stall,
  output logic [$clog2(DEPTH):0]   ll_count
);

  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned EntryW = REG_W + XLEN;

  logic              alu_req, ll_req, fifo_empty;
  logic              push, pop;
  logic [CountW-1:0] fifo_count;
  logic [EntryW-1:0] fifo_head;
  wb_req_t           sel, head_req;

  logic                wb_en_q, wb_en_d;
  logic [REG_W-1:0]    wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  // Ready depends only on registered occupancy, never on this cycle's ALU traffic.
  assign ll_ready   = fifo_count < CountW'(DEPTH);
  assign fifo_empty = fifo_count == '0;
  assign alu_req    = alu_valid && (alu_rd != REG_ZERO);
  assign ll_req     = ll_valid && ll_ready && (ll_rd != REG_ZERO);
  assign head_req   = '{valid: 1'b1, rd: fifo_head[EntryW-1:XLEN], data: fifo_head[XLEN-1:0]};

  always_comb begin
    sel  = '{valid: 1'b0, rd: REG_ZERO, data: '0};
    pop  = 1'b0;
    push = 1'b0;
    if (alu_req) begin
      sel  = '{valid: 1'b1, rd: alu_rd, data: alu_data};
      push = ll_req;
    end else if (!fifo_empty) begin
      sel  = head_req;
      pop  = 1'b1;
      push = ll_req;
    end else if (ll_req) begin
      sel = '{valid: 1'b1, rd: ll_rd, data: ll_data};
    end
  end

  always_comb begin
    wb_en_d   = sel.valid;
    wb_reg_d  = sel.valid ? sel.rd : wb_reg_q;
    wb_data_d = sel.valid ? sel.data : wb_data_q;
    starve_d  = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_reg_q  <= REG_ZERO;
      wb_data_q <= '0;
      starve_q  <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      starve_q  <= starve_d;
    end
  end

  wb_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i ({ll_rd, ll_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign wb_en     = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign alu_stall = starve_q == StarveW'(STARVE_LIMIT);
  assign ll_count  = fifo_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with DEPTH=2, STARVE_LIMIT=4.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        alu_stall;
  logic [1:0]  ll_count;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ll_valid  (ll_valid),
    .ll_ready  (ll_ready),
    .ll_rd     (ll_rd),
    .ll_data   (ll_data),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .alu_stall (alu_stall),
    .ll_count  (ll_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ll_valid  = 1'b0; ll_rd  = '0; ll_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({wb_en, wb_reg, wb_data} !== {1'b0, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_wb: got en=%b reg=%0d data=%h want 0/0/0", wb_en, wb_reg, wb_data);
    end
    checks++;
    if ({ll_ready, ll_count, alu_stall} !== {1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_status: got ready=%b count=%0d stall=%b want 1/0/0",
               ll_ready, ll_count, alu_stall);
    end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    alu_valid = 1'b0;
    checks++;
    if ({wb_en, wb_reg, wb_data} !== {1'b1, 5'd5, 32'h1234}) begin
      failures++;
      $display("FAIL alu_only: got en=%b reg=%0d data=%h want 1/5/1234", wb_en, wb_reg, wb_data);
    end
    tick();
    checks++;
    if ({wb_en, wb_reg, wb_data} !== {1'b0, 5'd5, 32'h1234}) begin
      failures++;
      $display("FAIL alu_idle_hold: got en=%b reg=%0d data=%h want 0/5/1234",
               wb_en, wb_reg, wb_data);
    end
  endtask

  task automatic test_collision();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    ll_valid  = 1'b1; ll_rd  = 5'd7; ll_data  = 32'hB;
    tick();
    idle_inputs();
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count} !== {1'b1, 5'd3, 32'hA, 2'd1}) begin
      failures++;
      $display("FAIL collision_alu: got en=%b reg=%0d data=%h cnt=%0d want 1/3/a/1",
               wb_en, wb_reg, wb_data, ll_count);
    end
    tick();
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count} !== {1'b1, 5'd7, 32'hB, 2'd0}) begin
      failures++;
      $display("FAIL collision_ll: got en=%b reg=%0d data=%h cnt=%0d want 1/7/b/0",
               wb_en, wb_reg, wb_data, ll_count);
    end
  endtask

  task automatic test_fill_backpressure();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    ll_valid  = 1'b1; ll_rd  = 5'd10; ll_data = 32'h100;
    tick();
    ll_rd = 5'd11; ll_data = 32'h101;
    tick();
    checks++;
    if ({ll_count, ll_ready, alu_stall} !== {2'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fill_full: got cnt=%0d ready=%b stall=%b want 2/0/0",
               ll_count, ll_ready, alu_stall);
    end
    // Third result is offered but must be held while ready is low.
    ll_rd = 5'd12; ll_data = 32'h102;
    tick();
    tick();
    checks++;
    if ({alu_stall, ll_count} !== {1'b0, 2'd2}) begin
      failures++;
      $display("FAIL starve_early: got stall=%b cnt=%0d want 0/2", alu_stall, ll_count);
    end
    tick();
    checks++;
    if (alu_stall !== 1'b1) begin
      failures++;
      $display("FAIL starve_limit: got stall=%b want 1", alu_stall);
    end
    alu_data = 32'h22;
    tick();
    checks++;
    if ({wb_en, wb_reg, wb_data, alu_stall, ll_count} !== {1'b1, 5'd1, 32'h22, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL alu_wins_stall: got en=%b reg=%0d data=%h stall=%b cnt=%0d want 1/1/22/1/2",
               wb_en, wb_reg, wb_data, alu_stall, ll_count);
    end
    alu_valid = 1'b0;
    tick();
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count, alu_stall, ll_ready}
        !== {1'b1, 5'd10, 32'h100, 2'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL drain_first: got en=%b reg=%0d data=%h cnt=%0d stall=%b ready=%b want 1/10/100/1/0/1",
               wb_en, wb_reg, wb_data, ll_count, alu_stall, ll_ready);
    end
    // Held result transfers now, concurrent with the second pop.
    tick();
    ll_valid = 1'b0;
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count} !== {1'b1, 5'd11, 32'h101, 2'd1}) begin
      failures++;
      $display("FAIL drain_second: got en=%b reg=%0d data=%h cnt=%0d want 1/11/101/1",
               wb_en, wb_reg, wb_data, ll_count);
    end
    tick();
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count} !== {1'b1, 5'd12, 32'h102, 2'd0}) begin
      failures++;
      $display("FAIL drain_third: got en=%b reg=%0d data=%h cnt=%0d want 1/12/102/0",
               wb_en, wb_reg, wb_data, ll_count);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    ll_valid  = 1'b1; ll_rd  = 5'd9; ll_data  = 32'hC0;
    tick();
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count} !== {1'b1, 5'd9, 32'hC0, 2'd0}) begin
      failures++;
      $display("FAIL x0_bypass: got en=%b reg=%0d data=%h cnt=%0d want 1/9/c0/0",
               wb_en, wb_reg, wb_data, ll_count);
    end
    alu_valid = 1'b0;
    ll_rd = 5'd0; ll_data = 32'h55;
    tick();
    idle_inputs();
    checks++;
    if ({wb_en, wb_reg, wb_data, ll_count} !== {1'b0, 5'd9, 32'hC0, 2'd0}) begin
      failures++;
      $display("FAIL x0_ll_discard: got en=%b reg=%0d data=%h cnt=%0d want 0/9/c0/0",
               wb_en, wb_reg, wb_data, ll_count);
    end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
    ll_valid  = 1'b1; ll_rd  = 5'd20; ll_data = 32'h200;
    tick();
    ll_rd = 5'd21; ll_data = 32'h201;
    tick();
    idle_inputs();
    checks++;
    if (ll_count !== 2'd2) begin
      failures++;
      $display("FAIL rst_mid_setup: got cnt=%0d want 2", ll_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({wb_en, wb_reg, ll_count, ll_ready, alu_stall} !== {1'b0, 5'd0, 2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_clear: got en=%b reg=%0d cnt=%0d ready=%b stall=%b want 0/0/0/1/0",
               wb_en, wb_reg, ll_count, ll_ready, alu_stall);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({wb_en, wb_reg, ll_count} !== {1'b0, 5'd0, 2'd0}) begin
        failures++;
        $display("FAIL rst_mid_no_stale[%0d]: got en=%b reg=%0d cnt=%0d want 0/0/0",
                 i, wb_en, wb_reg, ll_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_only();
    test_collision();
    test_fill_backpressure();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
